// File: rtl/wb.sv
// Write-back stage: commits register-file writes, owns HI/LO and CP0 state,
// and raises syscall/overflow exceptions and eret redirects.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   WB_valid, MEM_WB_bus_r  valid flag and 120-bit bus from the memory stage
//   rf_wen/rf_wdest/rf_wdata  register-file write port
//   WB_over, WB_wdest, WB_pc  completion, hazard destination, display PC
//   exc_valid/exc_pc/cancel   redirect request, target and younger-stage flush
//   HI_data, LO_data          current HI/LO
//   cp0r_status/cause/epc     current CP0 registers
module wb #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         WB_valid,
    input  logic [119:0] MEM_WB_bus_r,
    output logic         rf_wen,
    output logic [4:0]   rf_wdest,
    output logic [31:0]  rf_wdata,
    output logic         WB_over,
    output logic [4:0]   WB_wdest,
    output logic         exc_valid,
    output logic [31:0]  exc_pc,
    output logic         cancel,
    output logic [31:0]  WB_pc,
    output logic [31:0]  HI_data,
    output logic [31:0]  LO_data,
    output logic [31:0]  cp0r_status,
    output logic [31:0]  cp0r_cause,
    output logic [31:0]  cp0r_epc
);

    localparam logic [7:0]  ADDR_STATUS = 8'h60;
    localparam logic [7:0]  ADDR_CAUSE  = 8'h68;
    localparam logic [7:0]  ADDR_EPC    = 8'h70;

    localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_MASK  = 32'h0000_0300;

    localparam logic [4:0]  CODE_OV  = 5'd12;
    localparam logic [4:0]  CODE_SYS = 5'd8;

    // Bus fields
    logic [31:0] pc;
    logic        overflow;
    logic        eret;
    logic        syscall;
    logic [7:0]  cp0r_addr;
    logic        mfc0;
    logic        mtc0;
    logic        mflo;
    logic        mfhi;
    logic        lo_write;
    logic        hi_write;
    logic [31:0] lo_result;
    logic [31:0] mem_result;
    logic [4:0]  bus_wdest;
    logic        bus_wen;
    logic        unused_bit;

    assign pc         = MEM_WB_bus_r[31:0];
    assign overflow   = MEM_WB_bus_r[32];
    assign eret       = MEM_WB_bus_r[33];
    assign syscall    = MEM_WB_bus_r[34];
    assign cp0r_addr  = MEM_WB_bus_r[42:35];
    assign mfc0       = MEM_WB_bus_r[43];
    assign mtc0       = MEM_WB_bus_r[44];
    assign mflo       = MEM_WB_bus_r[45];
    assign mfhi       = MEM_WB_bus_r[46];
    assign lo_write   = MEM_WB_bus_r[47];
    assign hi_write   = MEM_WB_bus_r[48];
    assign lo_result  = MEM_WB_bus_r[80:49];
    assign mem_result = MEM_WB_bus_r[112:81];
    assign bus_wdest  = MEM_WB_bus_r[117:113];
    assign bus_wen    = MEM_WB_bus_r[118];
    assign unused_bit = MEM_WB_bus_r[119];

    // Architectural state
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic [31:0] status_n;
    logic [31:0] cause_n;
    logic [31:0] epc_n;

    // Qualified events
    logic        exc_act;
    logic        eret_act;
    logic        mtc0_act;
    logic [4:0]  exc_code;
    logic [31:0] cp0_rdata;

    assign exc_act  = WB_valid & (overflow | syscall);
    assign eret_act = WB_valid & eret & ~overflow & ~syscall;
    assign mtc0_act = WB_valid & mtc0 & ~overflow & ~syscall;
    assign exc_code = overflow ? CODE_OV : CODE_SYS;

    // CP0 read port returns pre-update values
    always_comb begin
        cp0_rdata = 32'h0;
        if (cp0r_addr == ADDR_STATUS) begin
            cp0_rdata = status;
        end else if (cp0r_addr == ADDR_CAUSE) begin
            cp0_rdata = cause;
        end else if (cp0r_addr == ADDR_EPC) begin
            cp0_rdata = epc;
        end
    end

    // Next-state for HI/LO
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (WB_valid && !overflow) begin
            if (hi_write) begin
                hi_n = mem_result;
            end
            if (lo_write) begin
                lo_n = lo_result;
            end
        end
    end

    // Next-state for CP0. An exception blocks mtc0; eret clears EXL
    // after any same-cycle mtc0 of STATUS so the return always wins.
    always_comb begin
        status_n = status;
        cause_n  = cause;
        epc_n    = epc;
        if (exc_act) begin
            cause_n = (cause & ~32'h0000_007C) | {25'h0, exc_code, 2'b00};
            // Nested exceptions keep the original return address
            if (!status[1]) begin
                epc_n = pc;
            end
            status_n = status | 32'h0000_0002;
        end else begin
            if (mtc0_act) begin
                if (cp0r_addr == ADDR_STATUS) begin
                    status_n = mem_result & STATUS_MASK;
                end else if (cp0r_addr == ADDR_CAUSE) begin
                    cause_n = (cause & ~CAUSE_MASK)
                            | (mem_result & CAUSE_MASK);
                end else if (cp0r_addr == ADDR_EPC) begin
                    epc_n = mem_result;
                end
            end
            if (eret_act) begin
                status_n = status_n & ~32'h0000_0002;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi     <= 32'h0;
            lo     <= 32'h0;
            status <= 32'h0;
            cause  <= 32'h0;
            epc    <= 32'h0;
        end else begin
            hi     <= hi_n;
            lo     <= lo_n;
            status <= status_n;
            cause  <= cause_n;
            epc    <= epc_n;
        end
    end

    // Register-file write port
    always_comb begin
        if (mfhi) begin
            rf_wdata = hi;
        end else if (mflo) begin
            rf_wdata = lo;
        end else if (mfc0) begin
            rf_wdata = cp0_rdata;
        end else begin
            rf_wdata = mem_result;
        end
    end

    assign rf_wen   = WB_valid & bus_wen & ~overflow;
    assign rf_wdest = bus_wdest;
    assign WB_wdest = bus_wdest & {5{WB_valid}};

    // Redirect
    assign exc_valid = exc_act | eret_act;
    assign cancel    = exc_valid;

    always_comb begin
        exc_pc = 32'h0;
        if (exc_act) begin
            exc_pc = EXC_ENTRY;
        end else if (eret_act) begin
            exc_pc = epc;
        end
    end

    assign WB_over     = WB_valid;
    assign WB_pc       = pc;
    assign HI_data     = hi;
    assign LO_data     = lo;
    assign cp0r_status = status;
    assign cp0r_cause  = cause;
    assign cp0r_epc    = epc;

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for the write-back stage: directed scenarios then
// randomized traffic against an architectural reference model.
module tb_wb;

    logic         clk;
    logic         resetn;
    logic         WB_valid;
    logic [119:0] MEM_WB_bus_r;
    logic         rf_wen;
    logic [4:0]   rf_wdest;
    logic [31:0]  rf_wdata;
    logic         WB_over;
    logic [4:0]   WB_wdest;
    logic         exc_valid;
    logic [31:0]  exc_pc;
    logic         cancel;
    logic [31:0]  WB_pc;
    logic [31:0]  HI_data;
    logic [31:0]  LO_data;
    logic [31:0]  cp0r_status;
    logic [31:0]  cp0r_cause;
    logic [31:0]  cp0r_epc;

    wb dut (
        .clk          (clk),
        .resetn       (resetn),
        .WB_valid     (WB_valid),
        .MEM_WB_bus_r (MEM_WB_bus_r),
        .rf_wen       (rf_wen),
        .rf_wdest     (rf_wdest),
        .rf_wdata     (rf_wdata),
        .WB_over      (WB_over),
        .WB_wdest     (WB_wdest),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .cancel       (cancel),
        .WB_pc        (WB_pc),
        .HI_data      (HI_data),
        .LO_data      (LO_data),
        .cp0r_status  (cp0r_status),
        .cp0r_cause   (cp0r_cause),
        .cp0r_epc     (cp0r_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instruction fields
    logic [31:0] f_pc, f_mem, f_lo;
    logic [7:0]  f_addr;
    logic [4:0]  f_wdest;
    logic        f_ov, f_er, f_sc, f_mfc0, f_mtc0;
    logic        f_mflo, f_mfhi, f_lw, f_hw, f_wen;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_status, m_cause, m_epc;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_fields();
        f_pc = 0; f_mem = 0; f_lo = 0; f_addr = 0; f_wdest = 0;
        f_ov = 0; f_er = 0; f_sc = 0; f_mfc0 = 0; f_mtc0 = 0;
        f_mflo = 0; f_mfhi = 0; f_lw = 0; f_hw = 0; f_wen = 0;
    endtask

    task automatic set_bus();
        MEM_WB_bus_r = {1'b0, f_wen, f_wdest, f_mem, f_lo, f_hw, f_lw,
                        f_mfhi, f_mflo, f_mtc0, f_mfc0, f_addr,
                        f_sc, f_er, f_ov, f_pc};
    endtask

    function automatic logic [31:0] cp0_read(input logic [7:0] a);
        case (a)
            8'h60:   return m_status;
            8'h68:   return m_cause;
            8'h70:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_status = 0; m_cause = 0; m_epc = 0;
    endtask

    // Architectural effect of one committed instruction
    task automatic model_commit();
        logic exc;
        exc = f_ov | f_sc;
        if (!WB_valid) return;
        if (!f_ov && f_hw) m_hi = f_mem;
        if (!f_ov && f_lw) m_lo = f_lo;
        if (exc) begin
            m_cause[6:2] = f_ov ? 5'd12 : 5'd8;
            if (m_status[1] == 1'b0) m_epc = f_pc;
            m_status[1] = 1'b1;
        end else begin
            if (f_mtc0) begin
                if (f_addr == 8'h60) m_status = f_mem & 32'h0000_FF03;
                if (f_addr == 8'h68) m_cause[9:8] = f_mem[9:8];
                if (f_addr == 8'h70) m_epc = f_mem;
            end
            if (f_er) m_status[1] = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".hi"},     HI_data,     m_hi);
        chk({tag, ".lo"},     LO_data,     m_lo);
        chk({tag, ".status"}, cp0r_status, m_status);
        chk({tag, ".cause"},  cp0r_cause,  m_cause);
        chk({tag, ".epc"},    cp0r_epc,    m_epc);
    endtask

    task automatic check_outs(input string tag);
        logic        redirect;
        logic [31:0] wd;
        redirect = WB_valid & (f_ov | f_sc | f_er);
        if (f_mfhi)      wd = m_hi;
        else if (f_mflo) wd = m_lo;
        else if (f_mfc0) wd = cp0_read(f_addr);
        else             wd = f_mem;
        chk({tag, ".rf_wen"},   {31'h0, rf_wen},
            {31'h0, WB_valid & f_wen & ~f_ov});
        chk({tag, ".rf_wdest"}, {27'h0, rf_wdest}, {27'h0, f_wdest});
        chk({tag, ".rf_wdata"}, rf_wdata, wd);
        chk({tag, ".wb_over"},  {31'h0, WB_over}, {31'h0, WB_valid});
        chk({tag, ".wb_wdest"}, {27'h0, WB_wdest},
            WB_valid ? {27'h0, f_wdest} : 32'h0);
        chk({tag, ".exc_valid"}, {31'h0, exc_valid}, {31'h0, redirect});
        chk({tag, ".cancel"},    {31'h0, cancel},    {31'h0, redirect});
        chk({tag, ".wb_pc"},     WB_pc, f_pc);
        if (redirect)
            chk({tag, ".exc_pc"}, exc_pc,
                (f_ov | f_sc) ? 32'h0000_0000 : m_epc);
        check_regs(tag);
    endtask

    // Present the fields for one cycle, check, then commit at the edge
    task automatic step(input string tag);
        set_bus();
        #2;
        check_outs(tag);
        @(posedge clk);
        if (resetn) model_commit();
        else model_reset();
        #1;
    endtask

    initial begin
        model_reset();
        clear_fields();
        resetn   = 1'b0;
        WB_valid = 1'b1;
        f_sc     = 1'b1;
        f_pc     = 32'h0000_0040;
        set_bus();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");

        resetn   = 1'b1;
        WB_valid = 1'b0;
        step("idle_after_reset");
        check_regs("post_reset");

        // mult commit then mfhi
        clear_fields();
        WB_valid = 1'b1;
        f_hw = 1; f_lw = 1;
        f_mem = 32'h1234_5678; f_lo = 32'h9ABC_DEF0;
        step("mult");
        chk("mult.hi_const", HI_data, 32'h1234_5678);
        chk("mult.lo_const", LO_data, 32'h9ABC_DEF0);
        clear_fields();
        f_mfhi = 1; f_wen = 1; f_wdest = 5;
        set_bus();
        #2;
        chk("mfhi.data_const", rf_wdata, 32'h1234_5678);
        chk("mfhi.dest_const", {27'h0, rf_wdest}, 32'd5);
        step("mfhi");

        // mtc0 STATUS all ones, read back
        clear_fields();
        f_mtc0 = 1; f_addr = 8'h60; f_mem = 32'hFFFF_FFFF;
        step("mtc0_status");
        chk("status_const", cp0r_status, 32'h0000_FF03);
        clear_fields();
        f_mfc0 = 1; f_addr = 8'h60; f_wen = 1; f_wdest = 9;
        step("mfc0_status");

        // Clear EXL, then syscall
        clear_fields();
        f_mtc0 = 1; f_addr = 8'h60; f_mem = 32'h0;
        step("status_clr");
        clear_fields();
        f_sc = 1; f_pc = 32'h0000_0040;
        step("syscall");
        chk("sys.epc_const", cp0r_epc, 32'h0000_0040);
        chk("sys.code_const", {27'h0, cp0r_cause[6:2]}, 32'd8);

        // eret, then overflow
        clear_fields();
        f_er = 1;
        step("eret1");
        clear_fields();
        f_ov = 1; f_wen = 1; f_wdest = 3; f_hw = 1;
        f_mem = 32'hDEAD_BEEF; f_pc = 32'h0000_0100;
        step("overflow");
        chk("ov.hi_const", HI_data, 32'h1234_5678);
        chk("ov.epc_const", cp0r_epc, 32'h0000_0100);
        clear_fields();
        f_sc = 1; f_pc = 32'h0000_0200;
        step("nested_sys");
        chk("nested.epc_const", cp0r_epc, 32'h0000_0100);

        // eret to 0x100, then the same bus while invalid
        clear_fields();
        f_er = 1;
        set_bus();
        #2;
        chk("eret.pc_const", exc_pc, 32'h0000_0100);
        step("eret2");
        WB_valid = 1'b0;
        step("eret_invalid");

        // mtc0 EPC immediately followed by eret
        WB_valid = 1'b1;
        clear_fields();
        f_mtc0 = 1; f_addr = 8'h70; f_mem = 32'h0000_0ABC;
        step("mtc0_epc");
        clear_fields();
        f_er = 1;
        step("eret_new_epc");

        // Asynchronous reset in the middle of an exception
        clear_fields();
        f_hw = 1; f_mem = 32'h5555_AAAA;
        step("hi_set");
        clear_fields();
        f_sc = 1; f_pc = 32'h0000_0300;
        set_bus();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_regs("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check_regs("async_reset_hold");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            clear_fields();
            WB_valid = ($urandom % 4) != 0;
            f_pc    = $urandom;
            f_mem   = $urandom;
            f_lo    = $urandom;
            f_wdest = 5'($urandom);
            f_wen   = 1'($urandom);
            f_ov    = ($urandom % 8) == 0;
            f_sc    = ($urandom % 8) == 0;
            f_er    = ($urandom % 6) == 0;
            f_mfc0  = ($urandom % 5) == 0;
            f_mtc0  = ($urandom % 4) == 0;
            f_mfhi  = ($urandom % 6) == 0;
            f_mflo  = ($urandom % 6) == 0;
            f_hw    = ($urandom % 3) == 0;
            f_lw    = ($urandom % 3) == 0;
            r = $urandom % 4;
            f_addr = (r == 0) ? 8'h60 :
                     (r == 1) ? 8'h68 :
                     (r == 2) ? 8'h70 : 8'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
